// File: rtl/alu_vec_pkg.sv
// Shared opcode encoding and per-lane flag layout for the pipelined vector ALU.
// Flags are packed per lane as {V,C,N,Z}.
package alu_vec_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_AND = 3'b011,
      OP_OR  = 3'b100,
      OP_XOR = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } alu_op_e;

   localparam int unsigned FLAGS_PER_LANE = 4;
   localparam int unsigned FLG_Z          = 0;
   localparam int unsigned FLG_N          = 1;
   localparam int unsigned FLG_C          = 2;
   localparam int unsigned FLG_V          = 3;

endpackage

// File: rtl/alu_lane.sv
// Combinational single-lane datapath: result plus {V,C,N,Z} flags.
// Signed saturation of ADD/SUB/MUL is built only when ALU_VEC_SAT_EN is defined.
module alu_lane
   import alu_vec_pkg::*;
#(
   parameter int unsigned LANE_W = 16
) (
   input  logic [LANE_W-1:0]         a,
   input  logic [LANE_W-1:0]         b,
   input  alu_op_e                   opcode,
   output logic [LANE_W-1:0]         result,
   output logic [FLAGS_PER_LANE-1:0] flags
);

   localparam int unsigned SH_W = $clog2(LANE_W);

   logic [LANE_W:0]            sum;
   logic [LANE_W:0]            diff;
   logic [2*LANE_W-1:0]        uprod;
   logic signed [2*LANE_W-1:0] a_sx;
   logic signed [2*LANE_W-1:0] b_sx;
   logic signed [2*LANE_W-1:0] sprod;
   logic [2*LANE_W-1:0]        shl_w;
   logic [2*LANE_W-1:0]        shr_w;
   logic [SH_W-1:0]            amt;
   logic [LANE_W-1:0]          raw;
   logic                       c_f;
   logic                       v_f;
   logic                       sat_neg;

   always_comb begin
      amt   = b[SH_W-1:0];
      sum   = {1'b0, a} + {1'b0, b};
      diff  = {1'b0, a} - {1'b0, b};
      uprod = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
      a_sx  = $signed({{LANE_W{a[LANE_W-1]}}, a});
      b_sx  = $signed({{LANE_W{b[LANE_W-1]}}, b});
      sprod = a_sx * b_sx;
      // Widened shifts: the bit just past the lane boundary is the last one shifted out.
      shl_w = {{LANE_W{1'b0}}, a} << amt;
      shr_w = {a, {LANE_W{1'b0}}} >> amt;
   end

   always_comb begin
      raw     = '0;
      c_f     = 1'b0;
      v_f     = 1'b0;
      sat_neg = 1'b0;
      unique case (opcode)
         OP_ADD: begin
            raw     = sum[LANE_W-1:0];
            c_f     = sum[LANE_W];
            v_f     = (a[LANE_W-1] == b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
            sat_neg = a[LANE_W-1];
         end
         OP_SUB: begin
            raw     = diff[LANE_W-1:0];
            c_f     = diff[LANE_W];
            v_f     = (a[LANE_W-1] != b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
            sat_neg = a[LANE_W-1];
         end
         OP_MUL: begin
            raw     = uprod[LANE_W-1:0];
            c_f     = |uprod[2*LANE_W-1:LANE_W];
            v_f     = !((&sprod[2*LANE_W-1:LANE_W-1]) || !(|sprod[2*LANE_W-1:LANE_W-1]));
            sat_neg = sprod[2*LANE_W-1];
         end
         OP_AND: raw = a & b;
         OP_OR:  raw = a | b;
         OP_XOR: raw = a ^ b;
         OP_SHL: begin
            raw = shl_w[LANE_W-1:0];
            c_f = shl_w[LANE_W];
         end
         OP_SHR: begin
            raw = shr_w[2*LANE_W-1:LANE_W];
            c_f = shr_w[LANE_W-1];
         end
         default: ;
      endcase
   end

`ifdef ALU_VEC_SAT_EN
   always_comb begin
      result = raw;
      if (v_f && (opcode inside {OP_ADD, OP_SUB, OP_MUL})) begin
         result = sat_neg ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
      end
   end
`else
   logic unused_sat;
   assign unused_sat = sat_neg;
   assign result     = raw;
`endif

   always_comb begin
      flags        = '0;
      flags[FLG_Z] = (result == '0);
      flags[FLG_N] = result[LANE_W-1];
      flags[FLG_C] = c_f;
      flags[FLG_V] = v_f;
   end

endmodule

// File: rtl/alu_vec_pipe.sv
// Two-stage valid/ready pipelined vector ALU: S1 holds operands, S2 holds results.
// Optional per-lane signed saturation via ALU_VEC_SAT_EN (see alu_lane).
module alu_vec_pipe
   import alu_vec_pkg::*;
#(
   parameter  int unsigned LANES  = 16,
   parameter  int unsigned LANE_W = 16,
   localparam int unsigned VEC_W  = LANES * LANE_W,
   localparam int unsigned FLG_W  = FLAGS_PER_LANE * LANES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [VEC_W-1:0] a,
   input  logic [VEC_W-1:0] b,
   input  logic [2:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [VEC_W-1:0] result,
   output logic [FLG_W-1:0] flags
);

   logic             s1_valid_q, s1_valid_d;
   logic [VEC_W-1:0] a_q, a_d;
   logic [VEC_W-1:0] b_q, b_d;
   alu_op_e          op_q, op_d;
   logic             s2_valid_q, s2_valid_d;
   logic [VEC_W-1:0] result_q, result_d;
   logic [FLG_W-1:0] flags_q, flags_d;

   logic             s1_adv;
   logic             s2_adv;
   logic [VEC_W-1:0] lane_res;
   logic [FLG_W-1:0] lane_flg;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      alu_lane #(
         .LANE_W (LANE_W)
      ) u_lane (
         .a      (a_q[i*LANE_W +: LANE_W]),
         .b      (b_q[i*LANE_W +: LANE_W]),
         .opcode (op_q),
         .result (lane_res[i*LANE_W +: LANE_W]),
         .flags  (lane_flg[i*FLAGS_PER_LANE +: FLAGS_PER_LANE])
      );
   end

   always_comb begin
      // Ready ripples back combinationally, so a full pipe still accepts when output drains.
      s2_adv     = !s2_valid_q || out_ready;
      s1_adv     = !s1_valid_q || s2_adv;

      s1_valid_d = s1_valid_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      s2_valid_d = s2_valid_q;
      result_d   = result_q;
      flags_d    = flags_q;

      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            a_d  = a;
            b_d  = b;
            op_d = alu_op_e'(opcode);
         end
      end
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d = lane_res;
            flags_d  = lane_flg;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= OP_ADD;
         s2_valid_q <= 1'b0;
         result_q   <= '0;
         flags_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         s2_valid_q <= s2_valid_d;
         result_q   <= result_d;
         flags_q    <= flags_d;
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_alu_vec_pipe.sv
// Directed self-checking bench for alu_vec_pipe (default 16 lanes x 16 bits).
// Expectations follow ALU_VEC_SAT_EN when the bench is built with it defined.
module tb_alu_vec_pipe;

   localparam int unsigned LANES = 16;
   localparam int unsigned LW    = 16;
   localparam int unsigned VW    = LANES * LW;
   localparam int unsigned FW    = 4 * LANES;
   localparam int unsigned NVEC  = 15;

   typedef struct {
      logic [2:0]    op;
      logic [LW-1:0] a;
      logic [LW-1:0] b;
      logic [LW-1:0] res;
      logic [3:0]    flg;   // {V,C,N,Z}
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [VW-1:0] a;
   logic [VW-1:0] b;
   logic [2:0]    opcode;
   logic          out_valid;
   logic          out_ready;
   logic [VW-1:0] result;
   logic [FW-1:0] flags;

   int n_pass  = 0;
   int n_total = 0;
   vec_t tbl [NVEC];

   alu_vec_pipe #(
      .LANES  (LANES),
      .LANE_W (LW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [LW-1:0] al,
                        input logic [LW-1:0] bl);
      in_valid = v;
      opcode   = op;
      a        = {LANES{al}};
      b        = {LANES{bl}};
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [LW-1:0] av,
                               input logic [LW-1:0] bv, input logic [LW-1:0] r,
                               input logic [3:0] f);
      vec_t v;
      v.op = op; v.a = av; v.b = bv; v.res = r; v.flg = f;
      return v;
   endfunction

   initial begin
      logic [VW-1:0] exp_r;
      logic [FW-1:0] exp_f;

`ifdef ALU_VEC_SAT_EN
      tbl[0]  = mk(3'b000, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b1000);
      tbl[4]  = mk(3'b001, 16'h8000, 16'h0001, 16'h8000, 4'b1010);
      tbl[5]  = mk(3'b010, 16'h1234, 16'h9876, 16'h8000, 4'b1110);
`else
      tbl[0]  = mk(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010);
      tbl[4]  = mk(3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b1000);
      tbl[5]  = mk(3'b010, 16'h1234, 16'h9876, 16'h43F8, 4'b1100);
`endif
      tbl[1]  = mk(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101);
      tbl[2]  = mk(3'b001, 16'h0000, 16'h0001, 16'hFFFF, 4'b0110);
      tbl[3]  = mk(3'b001, 16'h1234, 16'h1234, 16'h0000, 4'b0001);
      tbl[6]  = mk(3'b010, 16'h0003, 16'h0004, 16'h000C, 4'b0000);
      tbl[7]  = mk(3'b011, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0010);
      tbl[8]  = mk(3'b100, 16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000);
      tbl[9]  = mk(3'b101, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0001);
      tbl[10] = mk(3'b110, 16'h8001, 16'h0001, 16'h0002, 4'b0100);
      tbl[11] = mk(3'b111, 16'h8001, 16'h0010, 16'h8001, 4'b0010);
      tbl[12] = mk(3'b111, 16'h8001, 16'h0001, 16'h4000, 4'b0100);
      tbl[13] = mk(3'b110, 16'h0001, 16'h00FF, 16'h8000, 4'b0010);
      tbl[14] = mk(3'b010, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0100);

      // Reset state
      rst       = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 3'b000, '0, '0);
      #12;
      check("rst_out_valid", VW'(out_valid), '0);
      check("rst_result", result, '0);
      check("rst_flags", VW'(flags), '0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("post_rst_in_ready", VW'(in_ready), VW'(1'b1));

      // Streamed table: one op per cycle, each result two edges after its drive cycle
      for (int j = 0; j <= int'(NVEC); j++) begin
         if (j < int'(NVEC)) drive(1'b1, tbl[j].op, tbl[j].a, tbl[j].b);
         else drive(1'b0, 3'b000, '0, '0);
         #1;
         check($sformatf("tbl_in_ready_%0d", j), VW'(in_ready), VW'(1'b1));
         step();
         if (j >= 1) begin
            check($sformatf("tbl_valid_%0d", j-1), VW'(out_valid), VW'(1'b1));
            check($sformatf("tbl_result_%0d", j-1), result, {LANES{tbl[j-1].res}});
            check($sformatf("tbl_flags_%0d", j-1), VW'(flags), VW'({LANES{tbl[j-1].flg}}));
         end
      end
      step();
      check("tbl_drained", VW'(out_valid), '0);

      // Lane independence: even lanes wrap with carry, odd lanes must stay 1
      in_valid = 1'b1;
      opcode   = 3'b000;
      for (int i = 0; i < int'(LANES); i++) begin
         a[i*LW +: LW]     = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
         b[i*LW +: LW]     = 16'h0001;
         exp_r[i*LW +: LW] = (i % 2 == 0) ? 16'h0000 : 16'h0001;
         exp_f[i*4 +: 4]   = (i % 2 == 0) ? 4'b0101 : 4'b0000;
      end
      step();
      drive(1'b0, 3'b000, '0, '0);
      check("lane_lat1_valid", VW'(out_valid), '0);
      step();
      check("lane_valid", VW'(out_valid), VW'(1'b1));
      check("lane_result", result, exp_r);
      check("lane_flags", VW'(flags), VW'(exp_f));
      step();

      // Backpressure: two accepts fill the pipe, then ready drops
      out_ready = 1'b0;
      drive(1'b1, 3'b000, 16'd10, 16'd1);
      #1 check("bp_ready0", VW'(in_ready), VW'(1'b1));
      step();
      drive(1'b1, 3'b000, 16'd11, 16'd1);
      #1 check("bp_ready1", VW'(in_ready), VW'(1'b1));
      check("bp_not_valid_yet", VW'(out_valid), '0);
      step();
      drive(1'b1, 3'b000, 16'd12, 16'd1);
      #1 check("bp_full_not_ready", VW'(in_ready), '0);
      check("bp_valid", VW'(out_valid), VW'(1'b1));
      check("bp_res0", result, {LANES{16'd11}});
      step();
      check("bp_stable_res", result, {LANES{16'd11}});
      check("bp_stable_ready", VW'(in_ready), '0);
      out_ready = 1'b1;
      #1 check("bp_full_ready", VW'(in_ready), VW'(1'b1));
      step();
      drive(1'b1, 3'b000, 16'd13, 16'd1);
      #1 check("bp_res1", result, {LANES{16'd12}});
      step();
      drive(1'b0, 3'b000, '0, '0);
      #1 check("bp_res2", result, {LANES{16'd13}});
      step();
      check("bp_res3", result, {LANES{16'd14}});
      check("bp_res3_valid", VW'(out_valid), VW'(1'b1));
      step();
      check("bp_empty", VW'(out_valid), '0);

      // Asynchronous reset with both stages full
      out_ready = 1'b0;
      drive(1'b1, 3'b001, 16'h0005, 16'h0002);
      step();
      step();
      drive(1'b0, 3'b000, '0, '0);
      #2;
      check("full_before_rst", VW'(out_valid), VW'(1'b1));
      rst = 1'b1;
      #1;
      check("arst_valid", VW'(out_valid), '0);
      check("arst_result", result, '0);
      check("arst_flags", VW'(flags), '0);
      step();
      rst       = 1'b0;
      out_ready = 1'b1;
      #1 check("arst_in_ready", VW'(in_ready), VW'(1'b1));
      drive(1'b1, 3'b100, 16'h00F0, 16'h0F00);
      step();
      drive(1'b0, 3'b000, '0, '0);
      check("after_rst_lat1", VW'(out_valid), '0);
      step();
      check("after_rst_valid", VW'(out_valid), VW'(1'b1));
      check("after_rst_result", result, {LANES{16'h0FF0}});
      step();
      check("after_rst_no_dup", VW'(out_valid), '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
